// File: rtl/vga_vram_arb_if.sv
// CPU-side access port of the VGA VRAM arbiter.
// Handshake: the master holds cpu_req/cpu_we/cpu_addr/cpu_wdata stable until it sees
// cpu_ack (a one-cycle pulse), then drops cpu_req in the following cycle; cpu_rdata
// is valid from the ack cycle until the next read completes.
interface vga_vram_arb_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_ack;
    logic [11:0] cpu_rdata;

    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_ack,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_ack,
        output cpu_rdata
    );
endinterface

// File: rtl/vga_vram_arb.sv
// Single-port VRAM arbiter: the display scan owns the RAM while valid=1, the CPU
// gets one access per IDLE->CAPT->DONE pass during blanking.
module vga_vram_arb #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic                pclk,
    input  logic                reset,
    input  logic [9:0]          h_addr,
    input  logic [9:0]          v_addr,
    input  logic                valid,
    vga_vram_arb_if.slave       cpu,
    output logic [18:0]         vram_addr,
    output logic                vram_we,
    output logic [11:0]         vram_wdata,
    input  logic [11:0]         vram_rdata,
    output logic [23:0]         vga_data,
    output logic [1:0]          state_dbg
);

    localparam logic [18:0] PIX_COUNT = 19'(H_RES * V_RES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [11:0] rdata_q, rdata_d;
    logic        valid_d_q, valid_d_d;
    logic        rd_ok_q, rd_ok_d;
    logic        rd_oor_q, rd_oor_d;

    logic [18:0] disp_addr;
    logic        in_range;
    logic        grant;

    // 640 is the common case; keep it to shifts so no multiplier is inferred.
    generate
        if (H_RES == 640) begin : g_shift_mul
            assign disp_addr = ({9'd0, v_addr} << 9) + ({9'd0, v_addr} << 7) + {9'd0, h_addr};
        end else begin : g_gen_mul
            assign disp_addr = 19'({9'd0, v_addr} * 19'(H_RES)) + {9'd0, h_addr};
        end
    endgenerate

    assign in_range = (cpu.cpu_addr < PIX_COUNT);
    assign grant    = (state_q == IDLE) && !valid && cpu.cpu_req;

    assign vram_addr  = valid ? disp_addr : cpu.cpu_addr;
    assign vram_we    = grant && cpu.cpu_we && in_range;
    assign vram_wdata = cpu.cpu_wdata;

    assign vga_data  = valid_d_q ? {vram_rdata[11:8], vram_rdata[11:8],
                                    vram_rdata[7:4],  vram_rdata[7:4],
                                    vram_rdata[3:0],  vram_rdata[3:0]} : 24'h0;
    assign cpu.cpu_ack   = ack_q;
    assign cpu.cpu_rdata = rdata_q;
    assign state_dbg     = state_q;

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        rdata_d   = rdata_q;
        valid_d_d = valid;
        rd_ok_d   = rd_ok_q;
        rd_oor_d  = rd_oor_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = CAPT;
                    rd_ok_d  = !cpu.cpu_we && in_range;
                    rd_oor_d = !cpu.cpu_we && !in_range;
                end
            end
            CAPT: begin
                // RAM output here belongs to the grant-cycle address, whatever valid does now.
                state_d = DONE;
                ack_d   = 1'b1;
                if (rd_ok_q) begin
                    rdata_d = vram_rdata;
                end else if (rd_oor_q) begin
                    rdata_d = 12'h000;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            rdata_q   <= 12'h000;
            valid_d_q <= 1'b0;
            rd_ok_q   <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            valid_d_q <= valid_d_d;
            rd_ok_q   <= rd_ok_d;
            rd_oor_q  <= rd_oor_d;
        end
    end

endmodule

// File: tb/tb_vga_vram_arb.sv
// Directed bench for vga_vram_arb: a table of display-address vectors plus
// hand-written CPU transaction sequences against a behavioural 1-cycle VRAM.
module tb_vga_vram_arb;

    logic        pclk;
    logic        reset;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        valid;
    logic [18:0] vram_addr;
    logic        vram_we;
    logic [11:0] vram_wdata;
    logic [11:0] vram_rdata;
    logic [23:0] vga_data;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    vga_vram_arb_if cpu_if ();

    vga_vram_arb #(.H_RES(640), .V_RES(480)) dut (
        .pclk       (pclk),
        .reset      (reset),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .valid      (valid),
        .cpu        (cpu_if.slave),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .vga_data   (vga_data),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial pclk = 1'b0;
    always #20 pclk = ~pclk;

    // behavioural VRAM; out-of-range reads return junk so the DUT must mask them
    logic [11:0] mem [0:307199];
    logic        bd_we;
    logic [18:0] bd_addr;
    logic [11:0] bd_data;

    always @(posedge pclk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (vram_we && vram_addr < 19'd307200) begin
            mem[vram_addr] <= vram_wdata;
        end
        vram_rdata <= (vram_addr < 19'd307200) ? mem[vram_addr] : 12'hAAA;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [18:0] a, input logic [11:0] d);
        @(negedge pclk);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge pclk);
        bd_we   = 1'b0;
    endtask

    // one complete CPU access starting at a negedge with valid=0
    task automatic cpu_access(input string nm, input logic we, input logic [18:0] a,
                              input logic [11:0] wd, input logic exp_we,
                              input logic [11:0] exp_rd);
        valid            = 1'b0;
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = we;
        cpu_if.cpu_addr  = a;
        cpu_if.cpu_wdata = wd;
        #1;
        chk({nm, ".grant_we"},   32'(vram_we), 32'(exp_we));
        chk({nm, ".grant_addr"}, 32'(vram_addr), 32'(a));
        @(negedge pclk);
        chk({nm, ".capt_ack"},   32'(cpu_if.cpu_ack), 32'd0);
        chk({nm, ".capt_we"},    32'(vram_we), 32'd0);
        chk({nm, ".capt_state"}, 32'(state_dbg), 32'd1);
        @(negedge pclk);
        chk({nm, ".done_ack"},   32'(cpu_if.cpu_ack), 32'd1);
        chk({nm, ".done_rdata"}, 32'(cpu_if.cpu_rdata), 32'(exp_rd));
        cpu_if.cpu_req = 1'b0;
        @(negedge pclk);
        chk({nm, ".post_ack"},   32'(cpu_if.cpu_ack), 32'd0);
        chk({nm, ".post_state"}, 32'(state_dbg), 32'd0);
    endtask

    typedef struct {
        logic        v;
        logic [9:0]  h;
        logic [9:0]  y;
        logic        req;
        logic [18:0] caddr;
        logic [18:0] exp_addr;
        logic [23:0] exp_vga;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b1, 10'd5,   10'd2,   1'b1, 19'd777,     19'd1285,   24'h112233};
        vecs[1] = '{1'b1, 10'd0,   10'd0,   1'b1, 19'd5,       19'd0,      24'hAABBCC};
        vecs[2] = '{1'b1, 10'd639, 10'd479, 1'b1, 19'd9,       19'd307199, 24'hFF00FF};
        vecs[3] = '{1'b1, 10'd100, 10'd300, 1'b0, 19'd0,       19'd192100, 24'h77EE11};
        vecs[4] = '{1'b0, 10'd3,   10'd3,   1'b0, 19'h45678,   19'h45678,  24'h000000};
        vecs[5] = '{1'b1, 10'd639, 10'd0,   1'b1, 19'd42,      19'd639,    24'h000011};
        vecs[6] = '{1'b1, 10'd0,   10'd479, 1'b0, 19'd1,       19'd306560, 24'h880000};

        reset            = 1'b0;
        valid            = 1'b0;
        h_addr           = '0;
        v_addr           = '0;
        bd_we            = 1'b0;
        bd_addr          = '0;
        bd_data          = '0;
        cpu_if.cpu_req   = 1'b0;
        cpu_if.cpu_we    = 1'b0;
        cpu_if.cpu_addr  = '0;
        cpu_if.cpu_wdata = '0;

        preload(19'd1285,   12'h123);
        preload(19'd0,      12'hABC);
        preload(19'd307199, 12'hF0F);
        preload(19'd192100, 12'h7E1);
        preload(19'd639,    12'h001);
        preload(19'd306560, 12'h800);

        // reset state
        chk("rst.ack",   32'(cpu_if.cpu_ack), 32'd0);
        chk("rst.rdata", 32'(cpu_if.cpu_rdata), 32'd0);
        chk("rst.vga",   32'(vga_data), 32'd0);
        chk("rst.we",    32'(vram_we), 32'd0);
        chk("rst.state", 32'(state_dbg), 32'd0);
        reset = 1'b1;
        @(negedge pclk);

        // display address / pixel path vectors
        for (int i = 0; i < 7; i++) begin
            valid           = vecs[i].v;
            h_addr          = vecs[i].h;
            v_addr          = vecs[i].y;
            cpu_if.cpu_req  = vecs[i].req;
            cpu_if.cpu_we   = 1'b1;
            cpu_if.cpu_addr = vecs[i].caddr;
            #1;
            chk($sformatf("vec%0d.addr", i), 32'(vram_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d.we", i),   32'(vram_we), 32'd0);
            @(negedge pclk);
            chk($sformatf("vec%0d.vga", i),   32'(vga_data), 32'(vecs[i].exp_vga));
            chk($sformatf("vec%0d.state", i), 32'(state_dbg), 32'd0);
        end
        cpu_if.cpu_req = 1'b0;
        valid          = 1'b0;
        @(negedge pclk);

        // basic write/read, write keeps rdata, out-of-range handling
        cpu_access("wr1000", 1'b1, 19'd1000, 12'hF0A, 1'b1, 12'h000);
        chk("mem1000", 32'(mem[1000]), 32'h0F0A);
        cpu_access("rd1000", 1'b0, 19'd1000, 12'h000, 1'b0, 12'hF0A);
        cpu_access("rd192100", 1'b0, 19'd192100, 12'h000, 1'b0, 12'h7E1);
        cpu_access("wr2000", 1'b1, 19'd2000, 12'h555, 1'b1, 12'h7E1);
        chk("mem2000", 32'(mem[2000]), 32'h0555);
        cpu_access("wr_oor", 1'b1, 19'd307200, 12'hBAD, 1'b0, 12'h7E1);
        cpu_access("rd_oor", 1'b0, 19'd307200, 12'h000, 1'b0, 12'h000);

        // request held through an active line: no grant until valid falls
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = 1'b1;
        cpu_if.cpu_addr  = 19'd3000;
        cpu_if.cpu_wdata = 12'h3C3;
        valid            = 1'b1;
        v_addr           = 10'd7;
        for (int i = 0; i < 8; i++) begin
            h_addr = 10'(i * 13);
            #1;
            chk($sformatf("hold%0d.we", i),    32'(vram_we), 32'd0);
            chk($sformatf("hold%0d.addr", i),  32'(vram_addr), 32'(4480 + i * 13));
            @(negedge pclk);
            chk($sformatf("hold%0d.ack", i),   32'(cpu_if.cpu_ack), 32'd0);
            chk($sformatf("hold%0d.state", i), 32'(state_dbg), 32'd0);
        end
        cpu_access("wr3000", 1'b1, 19'd3000, 12'h3C3, 1'b1, 12'h000);
        chk("mem3000", 32'(mem[3000]), 32'h03C3);

        // valid rises right after the grant
        cpu_access("rd1000a", 1'b0, 19'd1000, 12'h000, 1'b0, 12'hF0A);
        cpu_if.cpu_req  = 1'b1;
        cpu_if.cpu_we   = 1'b0;
        cpu_if.cpu_addr = 19'd1000;
        #1;
        chk("vr.grant_addr", 32'(vram_addr), 32'd1000);
        @(negedge pclk);
        valid  = 1'b1;
        h_addr = 10'd5;
        v_addr = 10'd2;
        #1;
        chk("vr.disp_addr", 32'(vram_addr), 32'd1285);
        chk("vr.disp_we",   32'(vram_we), 32'd0);
        chk("vr.capt_ack",  32'(cpu_if.cpu_ack), 32'd0);
        @(negedge pclk);
        chk("vr.done_ack",   32'(cpu_if.cpu_ack), 32'd1);
        chk("vr.done_rdata", 32'(cpu_if.cpu_rdata), 32'h0F0A);
        chk("vr.vga",        32'(vga_data), 32'h112233);
        cpu_if.cpu_req = 1'b0;
        @(negedge pclk);
        chk("vr.post_ack", 32'(cpu_if.cpu_ack), 32'd0);
        valid = 1'b0;
        @(negedge pclk);

        // reset asserted in CAPT aborts the transaction
        valid            = 1'b0;
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = 1'b1;
        cpu_if.cpu_addr  = 19'd4000;
        cpu_if.cpu_wdata = 12'h999;
        #1;
        chk("ra.grant_we", 32'(vram_we), 32'd1);
        @(negedge pclk);
        chk("ra.capt_state", 32'(state_dbg), 32'd1);
        reset  = 1'b0;
        valid  = 1'b1;
        h_addr = 10'd0;
        v_addr = 10'd0;
        #1;
        chk("ra.ack",   32'(cpu_if.cpu_ack), 32'd0);
        chk("ra.rdata", 32'(cpu_if.cpu_rdata), 32'd0);
        chk("ra.vga",   32'(vga_data), 32'd0);
        chk("ra.we",    32'(vram_we), 32'd0);
        chk("ra.state", 32'(state_dbg), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk($sformatf("ra.hold%0d.ack", i), 32'(cpu_if.cpu_ack), 32'd0);
            chk($sformatf("ra.hold%0d.vga", i), 32'(vga_data), 32'd0);
        end
        chk("ra.mem4000", 32'(mem[4000]), 32'h0999);
        valid          = 1'b0;
        cpu_if.cpu_req = 1'b0;
        reset          = 1'b1;
        cpu_access("rd4000", 1'b0, 19'd4000, 12'h000, 1'b0, 12'h999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_vram_arb.md
VGA_VRAM_ARB -- requirements
Module: vga_vram_arb

Interface
REQ-001 SHALL have port pclk, input, 1, 25 MHz pixel clock; the only clock.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have ports h_addr, v_addr, input, 10 each, current pixel coordinates from the VGA timing block.
REQ-004 SHALL have port valid, input, 1, active-region flag from the VGA timing block.
REQ-005 SHALL have ports cpu_req and cpu_we, input, 1 each: access request and write enable (1 = write).
REQ-006 SHALL have ports cpu_addr, input, 19, and cpu_wdata, input, 12: word address and RGB444 write data.
REQ-007 SHALL have ports cpu_ack, output, 1, and cpu_rdata, output, 12: completion pulse and read data.
REQ-008 SHALL have ports vram_addr, output, 19; vram_we, output, 1; vram_wdata, output, 12; vram_rdata, input, 12: single-port synchronous VRAM with 1-cycle read latency.
REQ-009 SHALL have port vga_data, output, 24, RGB888 pixel to the VGA timing block.
REQ-010 SHALL have parameters H_RES, default 640, line width; V_RES, default 480, frame height.

Function
REQ-011 Display access SHALL have absolute priority: while valid=1, vram_addr = v_addr*H_RES + h_addr and vram_we = 0, combinationally.
REQ-012 Address arithmetic SHALL be 19-bit unsigned; v_addr*640 SHALL be formed as (v_addr<<9)+(v_addr<<7), with no truncation for v_addr <= 479.
REQ-013 vga_data SHALL lag h_addr/v_addr by exactly 1 pclk; the integrating top level delays hsync/vsync by 1 pclk to match.
REQ-014 A register valid_d SHALL capture valid each pclk; vga_data = valid_d ? {r,r,g,g,b,b} nibble-replicated from vram_rdata : 24'h0.
REQ-015 The CPU FSM SHALL have three states: IDLE, CAPT and DONE.
REQ-016 IDLE -> CAPT SHALL occur on a pclk edge where valid=0 and cpu_req=1 (the grant cycle).
REQ-017 In the grant cycle: vram_addr = cpu_addr; vram_we = cpu_we AND address-in-range; vram_wdata = cpu_wdata.
REQ-018 CAPT SHALL always go to DONE; on reads with an in-range address, cpu_rdata <= vram_rdata on that edge.
REQ-019 In DONE, cpu_ack SHALL be 1 for exactly one cycle; DONE SHALL always go to IDLE.
REQ-020 cpu_ack SHALL be 0 in all states other than DONE.
REQ-021 Access latency SHALL be: grant at cycle T, cpu_ack at T+2, cpu_rdata valid from T+2 until the next read completes.
REQ-022 A write SHALL leave cpu_rdata unchanged.
REQ-023 No new grant SHALL occur in CAPT or DONE; a request still held in IDLE is re-granted, so the CPU drops cpu_req in the cycle after cpu_ack.
REQ-024 valid rising during CAPT or DONE SHALL NOT corrupt the CPU transaction; capture uses RAM output from the grant-cycle address.
REQ-025 While valid=0, outside the grant cycle: vram_we = 0 and vram_addr holds cpu_addr.
REQ-026 Out-of-range cpu_addr (>= H_RES*V_RES = 307200) SHALL NOT write VRAM; it still completes with cpu_ack, and reads return cpu_rdata = 12'h000.
REQ-027 vram_we SHALL never be 1 while valid=1.

Reset
REQ-028 While reset=0: state = IDLE, cpu_ack = 0, cpu_rdata = 12'h000, valid_d = 0, and hence vga_data = 24'h0 and vram_we = 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no cpu_ack; the VRAM write for that transaction occurs only if its grant cycle completed before reset.
REQ-030 After reset=1, the first grant SHALL be possible on the first pclk edge meeting REQ-016.

Verification
REQ-031 Bench SHALL cover: valid=0; write addr 19'd1000, data 12'hF0A -> vram_we=1 one cycle, cpu_ack at T+2; then a read of 1000 -> cpu_rdata=12'hF0A at T+2.
REQ-032 Bench SHALL cover: valid=1, h_addr=5, v_addr=2 -> vram_addr=1285, vram_we=0; next cycle with vram_rdata=12'h123 -> vga_data=24'h112233.
REQ-033 Bench SHALL cover: cpu_req held high through an active line -> no grant and no vram_we until valid falls; grant occurs on the first valid=0 edge.
REQ-034 Bench SHALL cover: grant at T, valid rises at T+1 -> cpu_ack still at T+2 with correct data, and display addresses are driven from T+1.
REQ-035 Bench SHALL cover: write to addr 307200 -> vram_we stays 0, cpu_ack pulses; a read of 307200 -> cpu_rdata=12'h000.
REQ-036 Bench SHALL cover: reset pulled to 0 in CAPT -> cpu_ack never asserts, all outputs at REQ-028 values; normal access succeeds after release.
